// File: rtl/dark_min_filter_if.sv
// Pixel stream bundle: 8-bit sample plus hsync/vsync/de, one pixel per clock.
// No handshake: the source presents a pixel every cycle and the sink always accepts it; de=1 marks an active pixel.
interface dark_min_filter_if;
   logic [7:0] data;
   logic       hsync;
   logic       vsync;
   logic       de;

   modport master (output data, hsync, vsync, de);
   modport slave  (input  data, hsync, vsync, de);
endinterface

// File: rtl/dark_min_filter.sv
// 3x3 sliding minimum over the RGB-minimum stream, producing the dark-channel image.
// Output pixel (y,x) = min of rows y-2..y, columns x-2..x; fixed 3-cycle latency on data and sync.
module dark_min_filter #(
   parameter int H_ACTIVE = 1280,
   parameter int CW       = 11
) (
   input  logic         pixelclk,
   input  logic         reset,
   dark_min_filter_if.slave  upstream,
   dark_min_filter_if.master downstream
);

   localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [7:0] NEUTRAL = 8'hFF;

   function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   logic [CW-1:0] col;
   logic [1:0]    row;
   logic          de_d;
   logic          vs_d;
   logic          vs_rise;
   logic          de_fall;
   logic          in_range;
   logic [AW-1:0] addr;
   logic [1:0]    row_eff;

   logic [7:0] lb1 [H_ACTIVE];
   logic [7:0] lb2 [H_ACTIVE];

   logic [7:0] s1_cur, s1_up1, s1_up2;
   logic [2:0] s1_sync;
   logic [7:0] w0, w1, w2;
   logic [2:0] s2_sync;

   assign vs_rise  = upstream.vsync & ~vs_d;
   assign de_fall  = de_d & ~upstream.de;
   assign in_range = int'(col) < H_ACTIVE;
   assign addr     = in_range ? col[AW-1:0] : '0;
   // A frame-start edge applies to the pixel arriving with it, not only to later lines.
   assign row_eff  = vs_rise ? 2'd0 : row;

   always_ff @(posedge pixelclk or posedge reset) begin
      if (reset) begin
         col  <= '0;
         row  <= '0;
         de_d <= 1'b0;
         vs_d <= 1'b0;
      end else begin
         de_d <= upstream.de;
         vs_d <= upstream.vsync;
         if (!upstream.de)
            col <= '0;
         else if (col != '1)
            col <= col + 1'b1;
         if (vs_rise)
            row <= '0;
         else if (de_fall && row != 2'd2)
            row <= row + 2'd1;
      end
   end

   // Line storage is never reset; the row counter alone decides which taps are trusted.
   always_ff @(posedge pixelclk) begin
      if (upstream.de && in_range) begin
         lb1[addr] <= upstream.data;
         lb2[addr] <= lb1[addr];
      end
   end

   always_ff @(posedge pixelclk or posedge reset) begin
      if (reset) begin
         s1_cur  <= '0;
         s1_up1  <= '0;
         s1_up2  <= '0;
         s1_sync <= '0;
      end else begin
         s1_cur  <= upstream.data;
         s1_up1  <= (row_eff != 2'd0 && in_range) ? lb1[addr] : NEUTRAL;
         s1_up2  <= (row_eff == 2'd2 && in_range) ? lb2[addr] : NEUTRAL;
         s1_sync <= {upstream.hsync, upstream.vsync, upstream.de};
      end
   end

   // Window flushes to neutral during blanking so each line starts with x-1, x-2 = FF.
   always_ff @(posedge pixelclk or posedge reset) begin
      if (reset) begin
         w0      <= NEUTRAL;
         w1      <= NEUTRAL;
         w2      <= NEUTRAL;
         s2_sync <= '0;
      end else begin
         s2_sync <= s1_sync;
         if (s1_sync[0]) begin
            w0 <= min3(s1_cur, s1_up1, s1_up2);
            w1 <= w0;
            w2 <= w1;
         end else begin
            w0 <= NEUTRAL;
            w1 <= NEUTRAL;
            w2 <= NEUTRAL;
         end
      end
   end

   always_ff @(posedge pixelclk or posedge reset) begin
      if (reset) begin
         downstream.data  <= '0;
         downstream.hsync <= 1'b0;
         downstream.vsync <= 1'b0;
         downstream.de    <= 1'b0;
      end else begin
         downstream.data  <= s2_sync[0] ? min3(w0, w1, w2) : 8'h00;
         downstream.hsync <= s2_sync[2];
         downstream.vsync <= s2_sync[1];
         downstream.de    <= s2_sync[0];
      end
   end

endmodule
